// File: rtl/cpu_control_unit.sv
// cpu_control_unit: fetch / PC-increment / execute microsequencer for memory_system.
// Optional single-step WAIT state is enabled by defining CU_SINGLE_STEP_EN.
module cpu_control_unit #(
    parameter logic [2:0] PC_ADDR   = 3'b000,
    parameter logic [2:0] DPTR_ADDR = 3'b001,
    parameter logic [2:0] A_ADDR    = 3'b010,
    parameter logic [2:0] ACC_ADDR  = 3'b111,
    parameter logic [2:0] ALU_PASS  = 3'b000,
    parameter logic [2:0] ALU_INC   = 3'b110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef CU_SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [4:0] instruction,
    input  logic       C,
    input  logic       N,
    input  logic       P,
    input  logic       Z,
    output logic       ir_sclr,
    output logic       mar_sclr,
    output logic       enaf,
    output logic [2:0] selop,
    output logic [1:0] shamt,
    output logic       bank_wr_en,
    output logic [2:0] busB_addr,
    output logic [2:0] busC_addr,
    output logic       ir_en,
    output logic       mar_en,
    output logic       mdr_en,
    output logic       wr_rdn,
    output logic       mdr_alu_n,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_F_ADDR = 4'd2,
        S_F_MEM  = 4'd3,
        S_F_IR   = 4'd4,
        S_PC_INC = 4'd5,
        S_EXEC   = 4'd6,
        S_SKIP   = 4'd7,
        S_HALT   = 4'd8
`ifdef CU_SINGLE_STEP_EN
        ,
        S_WAIT   = 4'd9
`endif
    } state_t;

    typedef struct packed {
        logic       ir_sclr;
        logic       mar_sclr;
        logic       enaf;
        logic [2:0] selop;
        logic       bank_wr_en;
        logic [2:0] busb;
        logic [2:0] busc;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       wr_rdn;
        logic       mdr_alu_n;
        logic       halted;
    } ctrl_t;

`ifdef CU_SINGLE_STEP_EN
    localparam state_t S_LOOP = S_WAIT;
`else
    localparam state_t S_LOOP = S_F_ADDR;
`endif

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   illegal_q, illegal_d;

    // Branch flags are reserved for future opcodes.
    logic unused_flags;
    assign unused_flags = C ^ N ^ P;

    // State and registered Moore outputs; rst wins on every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing and EXEC opcode dispatch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_INIT;
            S_INIT:   state_d = S_F_ADDR;
            S_F_ADDR: state_d = S_F_MEM;
            S_F_MEM:  state_d = S_F_IR;
            S_F_IR:   state_d = S_PC_INC;
            S_PC_INC: state_d = S_EXEC;
            S_EXEC: begin
                unique case (instruction)
                    5'h04:   state_d = Z ? S_SKIP : S_LOOP;
                    5'h1F:   state_d = S_HALT;
                    default: state_d = S_LOOP;
                endcase
            end
            S_SKIP:   state_d = S_LOOP;
            S_HALT:   state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
            S_WAIT:   if (step) state_d = S_F_ADDR;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Decode the controls for the state being entered so they line up with it.
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        unique case (state_d)
            S_INIT: begin
                ctrl_d.ir_sclr  = 1'b1;
                ctrl_d.mar_sclr = 1'b1;
            end
            S_F_ADDR: begin
                ctrl_d.busb   = PC_ADDR;
                ctrl_d.selop  = ALU_PASS;
                ctrl_d.mar_en = 1'b1;
            end
            S_F_MEM: begin
                ctrl_d.mdr_alu_n = 1'b1;
                ctrl_d.mdr_en    = 1'b1;
            end
            S_F_IR:   ctrl_d.ir_en = 1'b1;
            S_PC_INC, S_SKIP: begin
                ctrl_d.busb       = PC_ADDR;
                ctrl_d.busc       = PC_ADDR;
                ctrl_d.selop      = ALU_INC;
                ctrl_d.bank_wr_en = 1'b1;
            end
            S_EXEC: begin
                unique case (instruction)
                    5'h01: begin
                        ctrl_d.busb       = ACC_ADDR;
                        ctrl_d.busc       = ACC_ADDR;
                        ctrl_d.selop      = ALU_INC;
                        ctrl_d.bank_wr_en = 1'b1;
                        ctrl_d.enaf       = 1'b1;
                    end
                    5'h02: begin
                        ctrl_d.busb       = DPTR_ADDR;
                        ctrl_d.busc       = DPTR_ADDR;
                        ctrl_d.selop      = ALU_INC;
                        ctrl_d.bank_wr_en = 1'b1;
                        ctrl_d.enaf       = 1'b1;
                    end
                    5'h03: begin
                        ctrl_d.busb       = ACC_ADDR;
                        ctrl_d.busc       = A_ADDR;
                        ctrl_d.selop      = ALU_PASS;
                        ctrl_d.bank_wr_en = 1'b1;
                    end
                    5'h00, 5'h04, 5'h1F: ;
                    default: illegal_d = 1'b1;
                endcase
            end
            S_HALT:   ctrl_d.halted = 1'b1;
            default:  ;
        endcase
    end

    assign ir_sclr    = ctrl_q.ir_sclr;
    assign mar_sclr   = ctrl_q.mar_sclr;
    assign enaf       = ctrl_q.enaf;
    assign selop      = ctrl_q.selop;
    assign shamt      = 2'b00;
    assign bank_wr_en = ctrl_q.bank_wr_en;
    assign busB_addr  = ctrl_q.busb;
    assign busC_addr  = ctrl_q.busc;
    assign ir_en      = ctrl_q.ir_en;
    assign mar_en     = ctrl_q.mar_en;
    assign mdr_en     = ctrl_q.mdr_en;
    assign wr_rdn     = ctrl_q.wr_rdn;
    assign mdr_alu_n  = ctrl_q.mdr_alu_n;
    assign halted     = ctrl_q.halted;
    assign illegal    = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed-vector bench for cpu_control_unit.
// Expected control words are hand-built per state and compared cycle by cycle.
module tb_cpu_control_unit;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_INIT = 4'd1;
    localparam logic [3:0] ST_FADDR = 4'd2;
    localparam logic [3:0] ST_FMEM = 4'd3;
    localparam logic [3:0] ST_FIR = 4'd4;
    localparam logic [3:0] ST_PCINC = 4'd5;
    localparam logic [3:0] ST_EXEC = 4'd6;
    localparam logic [3:0] ST_SKIP = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    logic       clk = 1'b0;
    logic       rst, start;
`ifdef CU_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif
    logic [4:0] instruction;
    logic       C, N, P, Z;
    logic       ir_sclr, mar_sclr, enaf, bank_wr_en;
    logic       ir_en, mar_en, mdr_en, wr_rdn, mdr_alu_n;
    logic       halted, illegal;
    logic [2:0] selop, busB_addr, busC_addr;
    logic [1:0] shamt;
    logic [3:0] state;

    int vec = 0;
    int miss = 0;

    logic [3:0]  es[8];
    logic [21:0] ec[8];
    logic [21:0] ctl;

    assign ctl = {ir_sclr, mar_sclr, enaf, selop, shamt, bank_wr_en,
                  busB_addr, busC_addr, ir_en, mar_en, mdr_en,
                  wr_rdn, mdr_alu_n, halted, illegal};

    cpu_control_unit dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef CU_SINGLE_STEP_EN
        .step(step),
`endif
        .instruction(instruction),
        .C(C), .N(N), .P(P), .Z(Z),
        .ir_sclr(ir_sclr), .mar_sclr(mar_sclr), .enaf(enaf),
        .selop(selop), .shamt(shamt), .bank_wr_en(bank_wr_en),
        .busB_addr(busB_addr), .busC_addr(busC_addr),
        .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .wr_rdn(wr_rdn), .mdr_alu_n(mdr_alu_n),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // Expected control word; wr_rdn and shamt are always zero.
    function automatic logic [21:0] cw(
        input logic sclr, input logic fl, input logic [2:0] op,
        input logic wen, input logic [2:0] b, input logic [2:0] c,
        input logic ir, input logic mar, input logic mdr,
        input logic src, input logic hlt, input logic ill);
        return {sclr, sclr, fl, op, 2'b00, wen, b, c,
                ir, mar, mdr, 1'b0, src, hlt, ill};
    endfunction

    localparam logic [21:0] CW_ZERO  = 22'h0;
    localparam logic [21:0] CW_INIT  = cw(1,0,3'd0,0,3'd0,3'd0,0,0,0,0,0,0);
    localparam logic [21:0] CW_FADDR = cw(0,0,3'd0,0,3'd0,3'd0,0,1,0,0,0,0);
    localparam logic [21:0] CW_FMEM  = cw(0,0,3'd0,0,3'd0,3'd0,0,0,1,1,0,0);
    localparam logic [21:0] CW_FIR   = cw(0,0,3'd0,0,3'd0,3'd0,1,0,0,0,0,0);
    localparam logic [21:0] CW_PCINC = cw(0,0,3'd6,1,3'd0,3'd0,0,0,0,0,0,0);
    localparam logic [21:0] CW_INCA  = cw(0,1,3'd6,1,3'd7,3'd7,0,0,0,0,0,0);
    localparam logic [21:0] CW_INCD  = cw(0,1,3'd6,1,3'd1,3'd1,0,0,0,0,0,0);
    localparam logic [21:0] CW_MOV   = cw(0,0,3'd0,1,3'd7,3'd2,0,0,0,0,0,0);
    localparam logic [21:0] CW_ILL   = cw(0,0,3'd0,0,3'd0,3'd0,0,0,0,0,0,1);
    localparam logic [21:0] CW_HALT  = cw(0,0,3'd0,0,3'd0,3'd0,0,0,0,0,1,0);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fetch();
        es[0] = ST_FADDR; ec[0] = CW_FADDR;
        es[1] = ST_FMEM;  ec[1] = CW_FMEM;
        es[2] = ST_FIR;   ec[2] = CW_FIR;
        es[3] = ST_PCINC; ec[3] = CW_PCINC;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; instruction = 5'h00;
        tick(); tick();
        es[0] = ST_IDLE;  ec[0] = CW_ZERO;
        es[1] = ST_IDLE;  ec[1] = CW_ZERO;
        es[2] = ST_INIT;  ec[2] = CW_INIT;
        es[3] = ST_FADDR; ec[3] = CW_FADDR;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) rst = 1'b0;
            if (i == 2) start = 1'b1;
            if (i == 3) start = 1'b0;
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL reset[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_inc_acc();
        instruction = 5'h01;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_INCA;
        es[5] = ST_FADDR; ec[5] = CW_FADDR;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL inc_acc[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_inc_dptr();
        instruction = 5'h02;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_INCD;
        es[5] = ST_FADDR; ec[5] = CW_FADDR;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL inc_dptr[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_mov();
        instruction = 5'h03;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_MOV;
        es[5] = ST_FADDR; ec[5] = CW_FADDR;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL mov[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_skz();
        instruction = 5'h04;
        Z = 1'b1;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_ZERO;
        es[5] = ST_SKIP;  ec[5] = CW_PCINC;
        es[6] = ST_FADDR; ec[6] = CW_FADDR;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL skz_taken[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
        Z = 1'b0;
        es[5] = ST_FADDR; ec[5] = CW_FADDR;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL skz_not_taken[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_illegal();
        instruction = 5'h0A;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_ILL;
        es[5] = ST_FADDR; ec[5] = CW_FADDR;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL illegal[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_nop();
        instruction = 5'h00;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_ZERO;
        es[5] = ST_FADDR; ec[5] = CW_FADDR;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL nop[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
    endtask

    task automatic test_halt();
        instruction = 5'h1F;
        load_fetch();
        es[4] = ST_EXEC;  ec[4] = CW_ZERO;
        es[5] = ST_HALT;  ec[5] = CW_HALT;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL halt_entry[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
        for (int i = 0; i < 20; i++) begin
            start = i[0];
            tick();
            if ({state, ctl} !== {ST_HALT, CW_HALT}) begin
                miss++;
                $display("FAIL halt_hold[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, ST_HALT, CW_HALT);
            end
            vec++;
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if ({state, ctl} !== {ST_IDLE, CW_ZERO}) begin
            miss++;
            $display("FAIL halt_reset: state=%0d ctl=%h, expected state=%0d ctl=%h",
                     state, ctl, ST_IDLE, CW_ZERO);
        end
        vec++;
    endtask

    task automatic test_reset_mid();
        instruction = 5'h01;
        es[0] = ST_INIT;  ec[0] = CW_INIT;
        es[1] = ST_FADDR; ec[1] = CW_FADDR;
        es[2] = ST_FMEM;  ec[2] = CW_FMEM;
        es[3] = ST_IDLE;  ec[3] = CW_ZERO;
        es[4] = ST_IDLE;  ec[4] = CW_ZERO;
        es[5] = ST_IDLE;  ec[5] = CW_ZERO;
        es[6] = ST_INIT;  ec[6] = CW_INIT;
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) start = 1'b0;
            if (i == 3) rst = 1'b1;
            if (i == 4) rst = 1'b0;
            if (i == 6) start = 1'b1;
            tick();
            if ({state, ctl} !== {es[i], ec[i]}) begin
                miss++;
                $display("FAIL reset_mid[%0d]: state=%0d ctl=%h, expected state=%0d ctl=%h",
                         i, state, ctl, es[i], ec[i]);
            end
            vec++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; instruction = 5'h00;
        C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;
        test_reset();
        test_inc_acc();
        test_inc_dptr();
        test_mov();
        test_skz();
        test_illegal();
        test_nop();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Microsequencer that drives every control input of memory_system.
- Runs a fixed fetch / PC-increment / execute loop and decodes the 5-bit instruction from the IR.
- Sits beside memory_system in the CPU top; its outputs connect directly to the memory_system control pins, and it reads back instruction and the flags C, N, P, Z.

Parameters:
- PC_ADDR, 3'b000, bank address of PC
- DPTR_ADDR, 3'b001, bank address of DPTR
- A_ADDR, 3'b010, bank address of A
- ACC_ADDR, 3'b111, bank address of ACC
- ALU_PASS, 3'b000, selop value: pass busB
- ALU_INC, 3'b110, selop value: busB+1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- instruction  in  5  IR contents from memory_system
- C, N, P, Z  in  1 each  ALU flags from memory_system
- ir_sclr, mar_sclr  out  1 each  synchronous clear of IR / MAR
- enaf  out  1  flag update enable
- selop  out  3  ALU operation
- shamt  out  2  shift amount; always 2'b00
- bank_wr_en  out  1  register bank write enable
- busB_addr, busC_addr  out  3 each  bank read / write addresses
- ir_en, mar_en, mdr_en  out  1 each  register load enables
- wr_rdn  out  1  1 = memory write, 0 = read
- mdr_alu_n  out  1  MDR source: 1 = memory, 0 = ALU
- halted  out  1  set in HALT state
- illegal  out  1  one-cycle pulse on an undefined opcode
- state  out  4  current FSM state, for debug

Behaviour:
- All outputs are registered Moore outputs decoded from state, except illegal, which is registered off the EXEC decode.
- Reset: state=IDLE; every output 0; halted=0.
- rst overrides everything on any cycle, including mid-fetch and mid-execute.
- IDLE: all controls 0. start=1 -> INIT.
- INIT (1 cycle): ir_sclr=1, mar_sclr=1 -> F_ADDR.
- F_ADDR: busB_addr=PC_ADDR, selop=ALU_PASS, mar_en=1 -> F_MEM.
- F_MEM: wr_rdn=0, mdr_alu_n=1, mdr_en=1 -> F_IR.
- F_IR: ir_en=1 -> PC_INC.
- PC_INC: busB_addr=busC_addr=PC_ADDR, selop=ALU_INC, bank_wr_en=1, enaf=0 -> EXEC.
- EXEC decodes instruction:
  - 5'h00 NOP: no controls -> F_ADDR.
  - 5'h01 INC_ACC: busB=busC=ACC_ADDR, selop=ALU_INC, bank_wr_en=1, enaf=1 -> F_ADDR.
  - 5'h02 INC_DPTR: same as INC_ACC with DPTR_ADDR.
  - 5'h03 MOV_A_ACC: busB=ACC_ADDR, busC=A_ADDR, selop=ALU_PASS, bank_wr_en=1, enaf=0 -> F_ADDR.
  - 5'h04 SKZ: no writes. Z=1 -> SKIP; Z=0 -> F_ADDR. Z is sampled in the EXEC cycle.
  - 5'h1F HALT -> HALT.
  - Any other opcode: behaves as NOP, illegal=1 for one cycle.
- SKIP: identical controls to PC_INC -> F_ADDR.
- HALT: all controls 0, halted=1. Exit only via rst; start is ignored.
- Timing: 5 cycles per instruction; SKZ taken costs 6.
- start is ignored outside IDLE.
- C, N, P are unused in this revision; their ports stay for future branch opcodes.
- Default in every state: wr_rdn=0, shamt=2'b00, unused busB/busC addresses=3'b000.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - FSM enters a WAIT state instead of F_ADDR after each EXEC or SKIP, with all controls 0.
  - step=1 in WAIT -> F_ADDR, so exactly one instruction runs per step pulse.
  - INIT still goes directly to F_ADDR.
- Undefined: no step port, no WAIT state; the loop is free-running.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> all outputs 0, state=IDLE. Pulse start -> ir_sclr=mar_sclr=1 for exactly 1 cycle.
- INC_ACC: instruction=5'h01 -> cycle sequence F_ADDR(mar_en=1) → F_MEM(mdr_en=1, mdr_alu_n=1) → F_IR(ir_en=1) → PC_INC(busC=0, selop=110, bank_wr_en=1) → EXEC(busB=busC=7, selop=110, enaf=1, bank_wr_en=1). Next F_ADDR occurs 5 cycles after the previous one.
- SKZ: instruction=5'h04 with Z=1 -> SKIP state follows with bank_wr_en=1, busC=0, 6-cycle instruction. With Z=0 -> F_ADDR follows directly, no extra PC write.
- MOV_A_ACC: instruction=5'h03 -> in EXEC busB=7, busC=2, selop=000, enaf=0.
- Illegal / HALT: instruction=5'h0A -> illegal=1 for one cycle, then F_ADDR. instruction=5'h1F -> halted=1 held for 20 cycles despite start pulses; rst -> IDLE with halted=0.
- Reset mid-op: assert rst during F_MEM -> next cycle state=IDLE, mdr_en=0. Returns to INIT only after start.
